// File: rtl/syn_mem_be_clr.sv
// Dual-port (1W/1R) synchronous RAM with byte-lane writes, registered read, and a reset-triggered clear engine.
// Optional per-lane even parity with O_perr is enabled by defining SYN_MEM_PARITY_EN.
module syn_mem_be_clr #(
  parameter int unsigned           C_ADDRSIZE = 10,
  parameter int unsigned           C_WORDSIZE = 32,
  parameter int unsigned           C_LANES    = 4,
  parameter logic [C_WORDSIZE-1:0] C_INIT_VAL = '0
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_wen,
  input  logic [C_LANES-1:0]    I_wbe,
  input  logic [C_ADDRSIZE-1:0] I_waddr,
  input  logic [C_WORDSIZE-1:0] I_wdata,
  input  logic                  I_ren,
  input  logic [C_ADDRSIZE-1:0] I_raddr,
  output logic [C_WORDSIZE-1:0] O_rdata,
  output logic                  O_rvalid,
`ifdef SYN_MEM_PARITY_EN
  output logic [C_LANES-1:0]    O_perr,
`endif
  output logic                  O_busy
);

  localparam int unsigned DEPTH = 1 << C_ADDRSIZE;
  // One extra counter bit keeps the last-address compare unambiguous.
  localparam logic [C_ADDRSIZE:0] LAST_ADDR = {1'b0, {C_ADDRSIZE{1'b1}}};
  localparam logic [C_ADDRSIZE:0] CNT_ONE   = {{C_ADDRSIZE{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                  state_r;
  logic [C_ADDRSIZE:0]     cnt_r;
  logic                    busy_r;
  logic [C_WORDSIZE-1:0]   rdata_r;
  logic                    rvalid_r;

  logic [C_WORDSIZE-1:0]   mem [DEPTH];

  logic                    run_s;
  logic                    wr_acc_s;
  logic                    rd_acc_s;
  logic                    mem_we_s;
  logic [C_ADDRSIZE-1:0]   mem_addr_s;
  logic [C_LANES-1:0]      mem_lanes_s;
  logic [C_WORDSIZE-1:0]   mem_wdata_s;
  logic [C_LANES-1:0]      fwd_s;
  logic [C_WORDSIZE-1:0]   rd_word_s;

`ifdef SYN_MEM_PARITY_EN
  logic [C_LANES-1:0]      par_mem [DEPTH];
  logic [C_LANES-1:0]      par_wr_s;
  logic [C_LANES-1:0]      perr_s;
  logic [C_LANES-1:0]      perr_r;

  function automatic logic [C_LANES-1:0] lane_parity(input logic [C_WORDSIZE-1:0] word);
    logic [C_LANES-1:0] p;
    for (int k = 0; k < C_LANES; k++) begin
      p[k] = ^word[8*k +: 8];
    end
    return p;
  endfunction
`endif

  // Request qualification and selection of the single memory write port.
  always_comb begin
    run_s       = (state_r == ST_RUN) && !I_rst;
    wr_acc_s    = run_s && I_wen;
    rd_acc_s    = run_s && I_ren;
    mem_we_s    = 1'b0;
    mem_addr_s  = I_waddr;
    mem_lanes_s = I_wbe;
    mem_wdata_s = I_wdata;
    if (state_r == ST_CLEAR) begin
      mem_we_s    = !I_rst;
      mem_addr_s  = cnt_r[C_ADDRSIZE-1:0];
      mem_lanes_s = {C_LANES{1'b1}};
      mem_wdata_s = C_INIT_VAL;
    end else begin
      mem_we_s    = wr_acc_s;
    end
  end

  // Read-side word with per-lane write-first forwarding on address collision.
  always_comb begin
    fwd_s     = '0;
    rd_word_s = mem[I_raddr];
    for (int k = 0; k < C_LANES; k++) begin
      if (wr_acc_s && (I_waddr == I_raddr) && I_wbe[k]) begin
        fwd_s[k]             = 1'b1;
        rd_word_s[8*k +: 8]  = I_wdata[8*k +: 8];
      end else begin
        fwd_s[k]             = 1'b0;
      end
    end
  end

`ifdef SYN_MEM_PARITY_EN
  // Parity generation for the write port and checking for the stored read word.
  always_comb begin
    par_wr_s = lane_parity(mem_wdata_s);
    perr_s   = '0;
    for (int k = 0; k < C_LANES; k++) begin
      if (fwd_s[k]) begin
        perr_s[k] = 1'b0;
      end else begin
        perr_s[k] = par_mem[I_raddr][k] ^ (^mem[I_raddr][8*k +: 8]);
      end
    end
  end

  // Parity storage, one bit per lane, written under the same lane mask as data.
  always_ff @(posedge I_clk) begin
    for (int k = 0; k < C_LANES; k++) begin
      if (mem_we_s && mem_lanes_s[k]) begin
        par_mem[mem_addr_s][k] <= par_wr_s[k];
      end
    end
  end
`endif

  // Data storage; contents are never reset, only overwritten by the clear walk.
  always_ff @(posedge I_clk) begin
    for (int k = 0; k < C_LANES; k++) begin
      if (mem_we_s && mem_lanes_s[k]) begin
        mem[mem_addr_s][8*k +: 8] <= mem_wdata_s[8*k +: 8];
      end
    end
  end

  // Clear/run controller with registered busy flag.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_r <= ST_CLEAR;
      cnt_r   <= '0;
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_ADDR) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b0;
          end else begin
            busy_r  <= 1'b1;
          end
        end
        ST_RUN: begin
          busy_r <= 1'b0;
        end
        default: begin
          state_r <= ST_CLEAR;
          cnt_r   <= '0;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // Registered read result; data holds between reads, valid is a one-cycle strobe.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      rdata_r  <= '0;
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= rd_acc_s;
      if (rd_acc_s) begin
        rdata_r <= rd_word_s;
      end
    end
  end

`ifdef SYN_MEM_PARITY_EN
  // Parity error flags are only meaningful alongside a valid read.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      perr_r <= '0;
    end else if (rd_acc_s) begin
      perr_r <= perr_s;
    end else begin
      perr_r <= '0;
    end
  end

  assign O_perr = perr_r;
`endif

  assign O_rdata  = rdata_r;
  assign O_rvalid = rvalid_r;
  assign O_busy   = busy_r;

endmodule
